// File: rtl/adc_pkg.sv
// Shared definitions for the ADC averaging path: default widths and the
// FILL/RUN state encoding used by the averaging filter.
package adc_pkg;
  localparam int ADC_DATA_W = 12;
  localparam int ADC_LOG2_N = 3;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } adc_state_e;
endpackage

// File: rtl/adc_hist_ram.sv
// N-entry sample history. One write port; the asynchronous read port shares
// the write address, so it returns the oldest entry about to be replaced.
module adc_hist_ram
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int LOG2_N = ADC_LOG2_N
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LOG2_N-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**LOG2_N];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/adc_avg_filter.sv
// Moving-average filter over the last N ADC samples: running sum updated the
// cycle after each strobe, mean registered one cycle later behind a valid/ready.
module adc_avg_filter
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int LOG2_N = ADC_LOG2_N
) (
  input  logic              clkADC,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              primed,
  output logic              overrun,
  input  logic              overrun_clr
);
  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;

  adc_state_e        r_state, w_state_nxt;
  logic [LOG2_N-1:0] r_wptr;
  logic [LOG2_N-1:0] r_fill_cnt;
  logic [SUM_W-1:0]  r_sum;
  logic              r_ld_pend;
  logic [DATA_W-1:0] r_avg_out;
  logic              r_avg_valid;
  logic              r_overrun;

  logic              w_accept;
  logic              w_last_fill;
  logic              w_emit;
  logic              w_hs;
  logic              w_ovr_set;
  logic [DATA_W-1:0] w_oldest_raw;
  logic [DATA_W-1:0] w_oldest;

  // Strobes during reset must not touch the history either.
  assign w_accept    = sample_valid & ~reset;
  assign w_last_fill = (r_state == ST_FILL) && (r_fill_cnt == LOG2_N'(N - 1));
  assign w_hs        = r_avg_valid & avg_ready;
  assign w_ovr_set   = r_ld_pend & r_avg_valid & ~avg_ready;

  adc_hist_ram #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_hist (
    .i_clk   (clkADC),
    .i_we    (w_accept),
    .i_addr  (r_wptr),
    .i_wdata (sample_in),
    .o_rdata (w_oldest_raw)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_oldest    = '0;
    case (r_state)
      ST_FILL: begin
        if (w_accept && w_last_fill) begin
          w_state_nxt = ST_RUN;
          w_emit      = 1'b1;
        end
      end
      ST_RUN: begin
        w_emit   = w_accept;
        w_oldest = w_oldest_raw;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clkADC) begin
    if (reset) r_state <= ST_FILL;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clkADC) begin
    if (reset) begin
      r_wptr      <= '0;
      r_fill_cnt  <= '0;
      r_sum       <= '0;
      r_ld_pend   <= 1'b0;
      r_avg_out   <= '0;
      r_avg_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + 1'b1;
        // Sum width holds N full-scale samples, so modular add/sub is exact.
        r_sum  <= r_sum + SUM_W'(sample_in) - SUM_W'(w_oldest);
        if (r_state == ST_FILL) r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      r_ld_pend <= w_emit;

      if (r_ld_pend) begin
        r_avg_out   <= r_sum[SUM_W-1:LOG2_N];
        r_avg_valid <= 1'b1;
      end else if (w_hs) begin
        r_avg_valid <= 1'b0;
      end

      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
    end
  end

  assign avg_out   = r_avg_out;
  assign avg_valid = r_avg_valid;
  assign overrun   = r_overrun;
  assign primed    = (r_state == ST_RUN);
endmodule

// File: tb/tb_adc_avg_filter.sv
// Bench for adc_avg_filter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a mean-of-last-N model.
module tb_adc_avg_filter;
  localparam int DW = 12;
  localparam int L  = 3;
  localparam int N  = 1 << L;

  logic          clkADC = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] avg_out;
  logic          avg_valid;
  logic          avg_ready = 1'b1;
  logic          primed;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  adc_avg_filter #(.DATA_W(DW), .LOG2_N(L)) dut (
    .clkADC       (clkADC),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .avg_ready    (avg_ready),
    .primed       (primed),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clkADC = ~clkADC;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: history of accepted samples since reset, mean of last N
  // appears two cycles after the strobe, then waits for a handshake.
  int hist[$];
  bit m_valid, m_ovr, m_primed, m_pend, m_set;
  int m_out, m_pval, m_sum;

  always @(posedge clkADC) begin
    if (reset) begin
      hist.delete();
      m_valid = 0; m_ovr = 0; m_primed = 0; m_pend = 0; m_out = 0; m_pval = 0;
    end else begin
      m_set = 0;
      if (m_pend) begin
        if (m_valid && !avg_ready) m_set = 1;
        m_out   = m_pval;
        m_valid = 1;
      end else if (m_valid && avg_ready) begin
        m_valid = 0;
      end
      if (m_set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      m_pend = 0;
      if (sample_valid) begin
        hist.push_back(int'(sample_in));
        if (hist.size() > N) void'(hist.pop_front());
        if (hist.size() == N) begin
          m_sum = 0;
          foreach (hist[i]) m_sum += hist[i];
          m_pval   = m_sum >> L;
          m_pend   = 1;
          m_primed = 1;
        end
      end
    end
  end

  int got[$];
  int vld_seen = 0;

  always @(negedge clkADC) begin
    if (chk_en) begin
      chk("avg_valid", int'(avg_valid), int'(m_valid));
      chk("primed", int'(primed), int'(m_primed));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (m_valid) chk("avg_out", int'(avg_out), m_out);
      if (avg_valid && avg_ready) got.push_back(int'(avg_out));
      if (avg_valid) vld_seen++;
    end
  end

  task automatic step(input logic [DW-1:0] v, input logic vld);
    @(posedge clkADC);
    #1;
    sample_in    = v;
    sample_valid = vld;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  int exp2[9] = '{'hFFF, 'hDFF, 'hBFF, 'h9FF, 'h7FF, 'h5FF, 'h3FF, 'h1FF, 'h000};

  initial begin
    idle(2);
    chk_en = 1'b1;
    chk("rst_avg_valid", int'(avg_valid), 0);
    chk("rst_avg_out", int'(avg_out), 0);
    chk("rst_primed", int'(primed), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;

    // Constant 0x800 window
    for (int i = 0; i < N; i++) step(12'h800, 1'b1);
    chk("t1_primed_k", int'(primed), 0);
    idle(1);
    chk("t1_primed_k1", int'(primed), 1);
    chk("t1_valid_k1", int'(avg_valid), 0);
    idle(1);
    chk("t1_valid_k2", int'(avg_valid), 1);
    chk("t1_out_k2", int'(avg_out), 'h800);
    idle(3);

    // Full-scale then zero: decreasing means, no sum wrap
    do_reset();
    got.delete();
    for (int i = 0; i < N; i++) step(12'hFFF, 1'b1);
    for (int i = 0; i < N; i++) step(12'h000, 1'b1);
    idle(4);
    chk("t2_count", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) chk("t2_value", got[i], exp2[i]);

    // Ramp 0..19 back-to-back across pointer wrap
    do_reset();
    got.delete();
    for (int i = 0; i < 20; i++) step(DW'(i), 1'b1);
    idle(4);
    chk("t3_count", got.size(), 13);
    if (got.size() == 13) begin
      chk("t3_first", got[0], 3);
      chk("t3_last", got[12], 15);
      for (int i = 0; i < 13; i++) chk("t3_value", got[i], i + 3);
    end

    // Overrun: two results without a consumer
    do_reset();
    for (int i = 0; i < N; i++) step(12'h100, 1'b1);
    idle(4);
    avg_ready = 1'b0;
    step(12'h900, 1'b1);
    idle(3);
    chk("t4_first_out", int'(avg_out), 'h200);
    chk("t4_no_ovr", int'(overrun), 0);
    step(12'h500, 1'b1);
    idle(3);
    chk("t4_ovr", int'(overrun), 1);
    chk("t4_valid", int'(avg_valid), 1);
    chk("t4_out", int'(avg_out), 'h280);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    chk("t4_ovr_clr", int'(overrun), 0);
    avg_ready = 1'b1;
    idle(3);

    // Reset mid-FILL discards partial window
    do_reset();
    for (int i = 0; i < 5; i++) step(DW'($urandom_range(0, 4095)), 1'b1);
    do_reset();
    vld_seen = 0;
    for (int i = 0; i < N - 1; i++) step(12'h100, 1'b1);
    idle(3);
    chk("t5_no_valid", vld_seen, 0);
    chk("t5_not_primed", int'(primed), 0);
    step(12'h100, 1'b1);
    idle(2);
    chk("t5_valid", int'(avg_valid), 1);
    chk("t5_out", int'(avg_out), 'h100);
    idle(2);

    // Load coinciding with handshake
    do_reset();
    for (int i = 0; i < N; i++) step(12'h100, 1'b1);
    idle(4);
    avg_ready = 1'b0;
    step(12'h900, 1'b1);
    idle(3);
    step(12'h500, 1'b1);
    idle(1);
    avg_ready = 1'b1;
    idle(1);
    avg_ready = 1'b0;
    chk("t6_valid", int'(avg_valid), 1);
    chk("t6_out", int'(avg_out), 'h280);
    chk("t6_ovr", int'(overrun), 0);
    avg_ready = 1'b1;
    idle(2);

    // Randomized traffic, including resets mid-stream
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       step(12'hFFF, $urandom_range(0, 9) < 6);
        1:       step(12'h000, $urandom_range(0, 9) < 6);
        default: step(DW'($urandom_range(0, 4095)), $urandom_range(0, 9) < 6);
      endcase
      avg_ready   = $urandom_range(0, 9) < 7;
      overrun_clr = $urandom_range(0, 19) == 0;
      reset       = $urandom_range(0, 299) == 0;
    end
    reset = 1'b0;
    overrun_clr = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
